dp_ff_array: RTL and testbench
==============================

// Module: dp_ff_array
// PURPOSE
//  Flip-flop storage array with one read/write port (port 0) and one read-only port (port 1).
//  Port 0 writes take a per-granule write mask. A sequenced clear sweep zeroes every set.
//  Used for cache tag/valid/dirty/LRU storage where lookup and update run in the same cycle.
// PARAMETERS
//  S_INDEX  4   set-index width; NUM_SETS = 2**S_INDEX
//  WIDTH    32  bits per set
//  GRAN     8   bits per write-mask bit; WIDTH % GRAN == 0; NMASK = WIDTH/GRAN
// PORTS
//  clk0    in   1        single clock, posedge
//  rst0    in   1        asynchronous, active-high reset
//  csb0    in   1        port-0 chip select, active low
//  web0    in   1        port-0 write enable, active low (read when high)
//  wmask0  in   NMASK    port-0 write mask; bit k covers din0[k*GRAN +: GRAN]
//  addr0   in   S_INDEX  port-0 set index
//  din0    in   WIDTH    port-0 write data
//  dout0   out  WIDTH    port-0 read data
//  csb1    in   1        port-1 chip select, active low
//  addr1   in   S_INDEX  port-1 set index
//  dout1   out  WIDTH    port-1 read data
//  clr     in   1        start clear sweep (one-cycle pulse)
//  busy    out  1        clear sweep in progress
// BEHAVIOUR
//  Reset (async, rst0=1):
//  - array = 0; web0_reg = 1; addr0_reg, addr1_reg, din0_reg, wmask0_reg = 0.
//  - FSM = IDLE; busy = 0. Hence dout0 = dout1 = 0.
//  - Reset mid-sweep aborts the sweep with the same result.
//  Capture (posedge, FSM IDLE, clr=0):
//  - csb0=0: register web0, addr0, wmask0, din0.
//  - csb0=1: web0_reg <= 1 (write is one-shot, never replayed); other regs hold.
//  - csb1=0: addr1_reg <= addr1; csb1=1: hold.
//  Commit: at the edge after capture, if web0_reg=0, array[addr0_reg] updates only the
//   granules with wmask0_reg bit set. wmask0_reg = 0 means no change.
//  Read:
//  - dout0 = array[addr0_reg]; dout1 = array[addr1_reg]; combinational from registered addresses.
//  - Read latency is 1 cycle from capture. Outputs stay stable while the address is held.
//  - After a write capture, dout0 shows pre-write data during the commit cycle and new data
//    from the next cycle on (unless bypass is enabled).
//  - Port-1 read of an address in its commit cycle: same rule as dout0.
//  FSM:
//  - IDLE -> CLEAR when clr=1 at a posedge. The capture in that cycle is dropped (clr wins).
//  - A write already in web0_reg still commits on that edge.
//  - CLEAR: counter starts at 0; each posedge zeroes array[cnt] and increments cnt.
//  - At cnt = NUM_SETS-1 that set is zeroed and the FSM returns to IDLE.
//  - busy = 1 exactly in CLEAR, i.e. NUM_SETS cycles.
//  - While busy: csb0/csb1 are ignored, web0_reg forced to 1, address regs hold, clr ignored.
//    dout* keep tracking array[addr*_reg], so they may show partially cleared data.
//  Counter is S_INDEX bits wide; wrap from NUM_SETS-1 is not used (exit happens first).
// CONFIGURATION
//  FF_ARRAY_BYPASS_EN defined:
//  - When web0_reg=0, dout0 and dout1 (if addr1_reg==addr0_reg) return the merged value:
//    din0_reg in masked granules, array data elsewhere.
//  - The effective write is visible in the commit cycle itself.
//  FF_ARRAY_BYPASS_EN undefined: no forwarding; pre-commit data as above.
// TESTING
//  1 reset -> dout0=dout1=0, busy=0; rst0 pulse between edges clears array with no clock edge.
//  2 write addr0=3, din0=32'hA5A5_5A5A, wmask0=4'b0101 over 32'hFFFF_FFFF, then read addr 3
//    -> dout0 = 32'hFFA5_FF5A.
//  3 hold csb0=1 after one write; a second write to the same set from a cycle-2 capture
//    must not be overwritten by a replay.
//  4 port-0 write addr 5 (=32'h1234_5678) with port-1 read addr 5 in the same capture cycle:
//    - commit cycle dout1 = old value without bypass, 32'h1234_5678 with FF_ARRAY_BYPASS_EN;
//    - next cycle dout1 = 32'h1234_5678 in both builds.
//  5 fill all 16 sets, pulse clr with a csb0=0 write in the same cycle:
//    - busy high exactly 16 cycles; write dropped; all sets read 0 afterwards;
//    - clr during busy has no effect.
//  6 assert rst0 at sweep cycle 7 -> busy=0 immediately; all sets 0; normal write works next cycle.

Source files
------------

// File: rtl/dp_ff_array_if.sv
// Port-0 read/write, port-1 read-only and clear-sweep signals of the flip-flop storage array.
// master drives requests (controller or bench); slave is the array itself.
interface dp_ff_array_if #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32,
  parameter int GRAN    = 8
);
  localparam int NMASK = WIDTH / GRAN;

  logic               csb0;
  logic               web0;
  logic [NMASK-1:0]   wmask0;
  logic [S_INDEX-1:0] addr0;
  logic [WIDTH-1:0]   din0;
  logic [WIDTH-1:0]   dout0;
  logic               csb1;
  logic [S_INDEX-1:0] addr1;
  logic [WIDTH-1:0]   dout1;
  logic               clr;
  logic               busy;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1, clr,
    input  dout0, dout1, busy
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1, clr,
    output dout0, dout1, busy
  );
endinterface

// File: rtl/dp_ff_array.sv
// Flip-flop set array: one masked read/write port, one read port, sequenced clear sweep.
// Optional FF_ARRAY_BYPASS_EN forwards the pending port-0 write onto both read ports.
//
// state | meaning
// IDLE  | capture port requests, commit pending writes
// CLEAR | zero one set per cycle, requests ignored, busy=1
module dp_ff_array #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32,
  parameter int GRAN    = 8
) (
  input  logic           clk0,
  input  logic           rst0,
  dp_ff_array_if.slave   bus
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int NMASK    = WIDTH / GRAN;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic               busy_q;
  logic [S_INDEX-1:0] cnt;

  logic               web0_reg;
  logic [S_INDEX-1:0] addr0_reg;
  logic [S_INDEX-1:0] addr1_reg;
  logic [NMASK-1:0]   wmask0_reg;
  logic [WIDTH-1:0]   din0_reg;

  logic [WIDTH-1:0]   mem [NUM_SETS];

  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   wr_merged;

  always_comb begin
    bit_mask = '0;
    for (int k = 0; k < NMASK; k++) begin
      bit_mask[k*GRAN +: GRAN] = {GRAN{wmask0_reg[k]}};
    end
    wr_merged = (mem[addr0_reg] & ~bit_mask) | (din0_reg & bit_mask);
  end

  // Commit of a captured write happens in every state; CLEAR keeps web0_reg high,
  // so commit and sweep never target the array on the same edge.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      cnt        <= '0;
      web0_reg   <= 1'b1;
      addr0_reg  <= '0;
      addr1_reg  <= '0;
      wmask0_reg <= '0;
      din0_reg   <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (!web0_reg) begin
        mem[addr0_reg] <= wr_merged;
      end

      case (state)
        IDLE: begin
          if (bus.clr) begin
            state    <= CLEAR;
            busy_q   <= 1'b1;
            cnt      <= '0;
            web0_reg <= 1'b1;
          end else begin
            if (!bus.csb0) begin
              web0_reg   <= bus.web0;
              addr0_reg  <= bus.addr0;
              wmask0_reg <= bus.wmask0;
              din0_reg   <= bus.din0;
            end else begin
              web0_reg <= 1'b1;
            end
            if (!bus.csb1) begin
              addr1_reg <= bus.addr1;
            end
          end
        end

        CLEAR: begin
          web0_reg <= 1'b1;
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == S_INDEX'(NUM_SETS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.dout0 = mem[addr0_reg];
    bus.dout1 = mem[addr1_reg];
`ifdef FF_ARRAY_BYPASS_EN
    if (!web0_reg) begin
      bus.dout0 = wr_merged;
      if (addr1_reg == addr0_reg) begin
        bus.dout1 = wr_merged;
      end
    end
`endif
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_dp_ff_array.sv
// Self-checking bench for dp_ff_array against a set-level behavioural model.
// Build with FF_ARRAY_BYPASS_EN defined to check the forwarding variant.
module tb_dp_ff_array;

  localparam int NS = 16;
`ifdef FF_ARRAY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;

  dp_ff_array_if bus ();

  dp_ff_array dut (
    .clk0 (clk0),
    .rst0 (rst0),
    .bus  (bus)
  );

  always #5 clk0 = ~clk0;

  int errors = 0;
  int checks = 0;

  // Model: array contents, last captured read addresses, a write waiting to land,
  // and how many sets the clear sweep still has to zero.
  logic [31:0] m_mem [NS];
  int          m_a0, m_a1;
  bit          p_v;
  int          p_a;
  logic [31:0] p_d;
  logic [3:0]  p_m;
  int          sweep_left;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int g = 0; g < 4; g++)
      if (mask[g]) r[g*8 +: 8] = new_v[g*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp0();
    if (BYPASS && p_v) return merge(m_mem[m_a0], p_d, p_m);
    return m_mem[m_a0];
  endfunction

  function automatic logic [31:0] exp1();
    if (BYPASS && p_v && m_a1 == p_a) return merge(m_mem[m_a1], p_d, p_m);
    return m_mem[m_a1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_mem[i] = '0;
    m_a0 = 0; m_a1 = 0; p_v = 1'b0; sweep_left = 0;
  endtask

  task automatic model_edge();
    if (p_v) m_mem[p_a] = merge(m_mem[p_a], p_d, p_m);
    p_v = 1'b0;
    if (sweep_left > 0) begin
      m_mem[NS - sweep_left] = '0;
      sweep_left--;
    end else if (bus.clr) begin
      sweep_left = NS;
    end else begin
      if (!bus.csb0) begin
        m_a0 = int'(bus.addr0);
        if (!bus.web0) begin
          p_v = 1'b1; p_a = int'(bus.addr0); p_d = bus.din0; p_m = bus.wmask0;
        end
      end
      if (!bus.csb1) m_a1 = int'(bus.addr1);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic csb0, input logic web0, input logic [3:0] mask,
                       input int a0, input logic [31:0] din, input logic csb1,
                       input int a1, input logic clr);
    bus.csb0 = csb0; bus.web0 = web0; bus.wmask0 = mask; bus.addr0 = 4'(a0);
    bus.din0 = din; bus.csb1 = csb1; bus.addr1 = 4'(a1); bus.clr = clr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'h0, 0, 32'h0, 1'b1, 0, 1'b0);
  endtask

  task automatic fill_all();
    for (int a = 0; a < NS; a++) begin
      drive(1'b0, 1'b0, 4'hF, a, $urandom | 32'h1, 1'b1, 0, 1'b0);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst0 = 1'b1;
    #12;
    checks++; if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout0: got %h want %h", bus.dout0, 32'h0); end
    checks++; if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL reset_dout1: got %h want %h", bus.dout1, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst0 = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 0, 32'h0, 1'b0, 0, 1'b0);
    tick();
    checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL pre_rst_write: got %h want %h", bus.dout0, exp0()); end
    #2 rst0 = 1'b1;
    #1 rst0 = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL rst_pulse_dout0: got %h want %h", bus.dout0, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_pulse_busy: got %b want 0", bus.busy); end
    tick();
    idle();
    tick();
    checks++; if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL rst_pulse_array: got %h want %h", bus.dout0, 32'h0); end
  endtask

  task automatic test_masked_write();
    drive(1'b0, 1'b0, 4'hF, 3, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'b0101, 3, 32'hA5A5_5A5A, 1'b1, 0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0, 3, 1'b0);
    tick();
    checks++; if (bus.dout0 !== 32'hFFA5_FF5A) begin errors++; $display("FAIL masked_dout0: got %h want %h", bus.dout0, 32'hFFA5_FF5A); end
    checks++; if (bus.dout1 !== exp1()) begin errors++; $display("FAIL masked_dout1: got %h want %h", bus.dout1, exp1()); end
    drive(1'b0, 1'b0, 4'h0, 3, 32'h0000_0000, 1'b1, 0, 1'b0);
    tick();
    idle();
    tick();
    checks++; if (bus.dout0 !== 32'hFFA5_FF5A) begin errors++; $display("FAIL zero_mask_dout0: got %h want %h", bus.dout0, 32'hFFA5_FF5A); end
  endtask

  task automatic test_no_replay();
    logic [31:0] a_val, b_val;
    a_val = $urandom;
    b_val = ~a_val;
    drive(1'b0, 1'b0, 4'hF, 7, a_val, 1'b1, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'b0011, 7, b_val, 1'b1, 0, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL no_replay_c%0d: got %h want %h", c, bus.dout0, exp0()); end
      tick();
    end
    checks++; if (bus.dout0 !== merge(a_val, b_val, 4'b0011)) begin errors++; $display("FAIL no_replay_final: got %h want %h", bus.dout0, merge(a_val, b_val, 4'b0011)); end
  endtask

  task automatic test_same_cycle_rw();
    drive(1'b0, 1'b0, 4'hF, 5, 32'h0BAD_F00D, 1'b1, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'hF, 5, 32'h1234_5678, 1'b0, 5, 1'b0);
    tick();
    idle();
    checks++; if (bus.dout1 !== (BYPASS ? 32'h1234_5678 : 32'h0BAD_F00D)) begin errors++; $display("FAIL rw_commit_dout1: got %h want %h", bus.dout1, BYPASS ? 32'h1234_5678 : 32'h0BAD_F00D); end
    checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL rw_commit_dout0: got %h want %h", bus.dout0, exp0()); end
    tick();
    checks++; if (bus.dout1 !== 32'h1234_5678) begin errors++; $display("FAIL rw_next_dout1: got %h want %h", bus.dout1, 32'h1234_5678); end
    checks++; if (bus.dout0 !== 32'h1234_5678) begin errors++; $display("FAIL rw_next_dout0: got %h want %h", bus.dout0, 32'h1234_5678); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), $urandom_range(0, NS - 1),
            $urandom, 1'($urandom), $urandom_range(0, NS - 1), 1'($urandom_range(0, 59) == 0));
      tick();
      checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL rand_dout0 c%0d: got %h want %h", c, bus.dout0, exp0()); end
      checks++; if (bus.dout1 !== exp1()) begin errors++; $display("FAIL rand_dout1 c%0d: got %h want %h", c, bus.dout1, exp1()); end
      checks++; if (bus.busy !== (sweep_left > 0)) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, bus.busy, sweep_left > 0); end
    end
    idle();
    for (int c = 0; c < 20 && sweep_left > 0; c++) tick();
  endtask

  task automatic test_clear();
    int busy_cycles;
    fill_all();
    drive(1'b0, 1'b0, 4'hF, 2, 32'hCAFE_0002, 1'b0, 9, 1'b1);
    tick();
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      checks++; if (bus.busy !== (sweep_left > 0)) begin errors++; $display("FAIL clr_busy c%0d: got %b want %b", c, bus.busy, sweep_left > 0); end
      checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL clr_dout0 c%0d: got %h want %h", c, bus.dout0, exp0()); end
      checks++; if (bus.dout1 !== exp1()) begin errors++; $display("FAIL clr_dout1 c%0d: got %h want %h", c, bus.dout1, exp1()); end
      if (bus.busy === 1'b1) busy_cycles++;
      if (sweep_left > 0)
        drive(1'b0, 1'b0, 4'hF, $urandom_range(0, NS - 1), $urandom | 32'h1, 1'b0,
              $urandom_range(0, NS - 1), 1'($urandom));
      else
        idle();
      tick();
    end
    checks++; if (busy_cycles != NS) begin errors++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cycles, NS); end
    for (int a = 0; a < NS; a++) begin
      drive(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0, NS - 1 - a, 1'b0);
      tick();
      checks++; if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL clr_set%0d_p0: got %h want %h", a, bus.dout0, 32'h0); end
      checks++; if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL clr_set%0d_p1: got %h want %h", NS - 1 - a, bus.dout1, 32'h0); end
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    fill_all();
    drive(1'b0, 1'b1, 4'h0, 12, 32'h0, 1'b0, 14, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'h0, 0, 32'h0, 1'b1, 0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 7; c++) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sweep7_busy: got %b want 1", bus.busy); end
    checks++; if (bus.dout0 !== exp0()) begin errors++; $display("FAIL sweep7_dout0: got %h want %h", bus.dout0, exp0()); end
    #2 rst0 = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL midrst_dout0: got %h want %h", bus.dout0, 32'h0); end
    checks++; if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL midrst_dout1: got %h want %h", bus.dout1, 32'h0); end
    rst0 = 1'b0;
    drive(1'b0, 1'b0, 4'hF, 4, 32'h5EED_0004, 1'b0, 12, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 4, 32'h0, 1'b1, 0, 1'b0);
    tick();
    checks++; if (bus.dout0 !== 32'h5EED_0004) begin errors++; $display("FAIL midrst_write: got %h want %h", bus.dout0, 32'h5EED_0004); end
    checks++; if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL midrst_set12: got %h want %h", bus.dout1, 32'h0); end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_masked_write();
    test_no_replay();
    test_same_cycle_rw();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
